param_register_file: RTL and testbench

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 51 +++++
 rtl/param_register_file.sv | 106 ++++++++++
 tb/tb_param_register_file.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the parameterised register file: default geometry
// and the control FSM state encoding.
package rf_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set by producer issue, cleared by the write that
// retires it, with a same-cycle bypass of the clearing write on both ports.
module rf_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    input  logic          sb_set,
    input  logic [AW-1:0] sb_a,
    input  logic          we,
    input  logic [AW-1:0] a3,
    input  logic [AW-1:0] a1,
    input  logic [AW-1:0] a2,
    output logic          pend1,
    output logic          pend2
);

    logic [NREG-1:0] pend_reg;
    logic [NREG-1:0] pend_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_bit
            if (gi == 0) begin : g_zero
                assign pend_next[gi] = 1'b0;
            end else begin : g_live
                logic set_hit;
                logic clr_hit;
                assign set_hit = run && sb_set && (sb_a == AW'(gi));
                assign clr_hit = run && we && (a3 == AW'(gi));
                // A new producer issuing in the same cycle as the old write wins.
                assign pend_next[gi] = set_hit ? 1'b1 :
                                       clr_hit ? 1'b0 : pend_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    assign pend1 = run && pend_reg[a1] && !(we && (a3 == a1));
    assign pend2 = run && pend_reg[a2] && !(we && (a3 == a2));

endmodule

// File: rtl/param_register_file.sv
// Two-read / one-write register file with self-initialisation after reset,
// write-through bypass, hard-wired zero register and a pending-write scoreboard.
module param_register_file
    import rf_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   rg_A1,
    input  logic [AW-1:0]   rg_A2,
    output logic [XLEN-1:0] rg_RD1,
    output logic [XLEN-1:0] rg_RD2,
    input  logic [AW-1:0]   rg_A3,
    input  logic [XLEN-1:0] rg_WD3,
    input  logic            rg_WE3,
    input  logic            rg_SB_SET,
    input  logic [AW-1:0]   rg_SB_A,
    output logic            rg_PEND1,
    output logic            rg_PEND2,
    output logic            rg_READY
);

    rf_state_t     state_reg;
    logic [AW-1:0] cnt_reg;
    logic          ready_reg;
    logic          run;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                INIT: begin
                    if (cnt_reg == AW'(NREG - 1)) begin
                        state_reg <= RUN;
                        ready_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RUN: begin
                    state_reg <= RUN;
                end
                default: begin
                    state_reg <= INIT;
                end
            endcase
        end
    end

    assign run      = (state_reg == RUN);
    assign rg_READY = ready_reg;

    // Storage is intentionally not reset; the INIT sweep rewrites every entry.
    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clock) begin
        if (!run) begin
            regs[cnt_reg] <= XLEN'(cnt_reg);
        end else if (rg_WE3 && (rg_A3 != '0)) begin
            regs[rg_A3] <= rg_WD3;
        end
    end

    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_data [2];

    assign rd_addr[0] = rg_A1;
    assign rd_addr[1] = rg_A2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rport
            logic wr_hit;
            assign wr_hit = run && rg_WE3 && (rg_A3 != '0) && (rg_A3 == rd_addr[gi]);
            assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 :
                                 wr_hit              ? rg_WD3 : regs[rd_addr[gi]];
        end
    endgenerate

    assign rg_RD1 = rd_data[0];
    assign rg_RD2 = rd_data[1];

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clock  (clock),
        .reset  (reset),
        .run    (run),
        .sb_set (rg_SB_SET),
        .sb_a   (rg_SB_A),
        .we     (rg_WE3),
        .a3     (rg_A3),
        .a1     (rg_A1),
        .a2     (rg_A2),
        .pend1  (rg_PEND1),
        .pend2  (rg_PEND2)
    );

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: directed scenarios plus randomized traffic
// checked against an array/flag reference model of the register file.
module tb_param_register_file;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clock = 1'b0;
    logic            reset;
    logic [AW-1:0]   rg_A1, rg_A2, rg_A3, rg_SB_A;
    logic [XLEN-1:0] rg_RD1, rg_RD2, rg_WD3;
    logic            rg_WE3, rg_SB_SET, rg_PEND1, rg_PEND2, rg_READY;

    int n_cmp = 0;
    int n_bad = 0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_pend [NREG];
    bit              m_run = 1'b0;

    always #5 clock = ~clock;

    param_register_file #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .rg_A1     (rg_A1),
        .rg_A2     (rg_A2),
        .rg_RD1    (rg_RD1),
        .rg_RD2    (rg_RD2),
        .rg_A3     (rg_A3),
        .rg_WD3    (rg_WD3),
        .rg_WE3    (rg_WE3),
        .rg_SB_SET (rg_SB_SET),
        .rg_SB_A   (rg_SB_A),
        .rg_PEND1  (rg_PEND1),
        .rg_PEND2  (rg_PEND2),
        .rg_READY  (rg_READY)
    );

    // Expected read data under the currently driven inputs.
    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (m_run && rg_WE3 && rg_A3 != 0 && rg_A3 == a) return rg_WD3;
        return m_regs[a];
    endfunction

    function automatic logic exp_pend(input logic [AW-1:0] a);
        if (!m_run) return 1'b0;
        return m_pend[a] && !(rg_WE3 && rg_A3 == a);
    endfunction

    task automatic drive(input logic we, input logic [AW-1:0] a3, input logic [XLEN-1:0] wd,
                         input logic set, input logic [AW-1:0] sba,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        rg_WE3 = we; rg_A3 = a3; rg_WD3 = wd;
        rg_SB_SET = set; rg_SB_A = sba;
        rg_A1 = a1; rg_A2 = a2;
        $display("txn we=%0d a3=%0d wd=%h set=%0d sba=%0d a1=%0d a2=%0d", we, a3, wd, set, sba, a1, a2);
        #2;
    endtask

    // Advance one clock and apply the architectural effect of the driven inputs.
    task automatic step();
        @(posedge clock);
        if (m_run) begin
            if (rg_WE3) begin
                if (rg_A3 != 0) m_regs[rg_A3] = rg_WD3;
                m_pend[rg_A3] = 1'b0;
            end
            if (rg_SB_SET && rg_SB_A != 0) m_pend[rg_SB_A] = 1'b1;
        end
        #1;
    endtask

    // Wait for READY with junk writes/sets that INIT must ignore.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        rg_WE3 = 1'b1; rg_A3 = 5'd3; rg_WD3 = 32'hAAAA_AAAA;
        rg_SB_SET = 1'b1; rg_SB_A = 5'd3; rg_A1 = 5'd3; rg_A2 = 5'd3;
        while (rg_READY !== 1'b1 && cycles < 100) begin
            #1;
            if (rg_PEND1 !== 1'b0) begin
                n_bad++;
                $display("FAIL init_pend: got %b want 0 at cycle %0d", rg_PEND1, cycles);
            end
            n_cmp++;
            @(posedge clock); #1;
            cycles++;
        end
        m_run = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = XLEN'(i);
            m_pend[i] = 1'b0;
        end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        int cycles;
        reset = 1'b0;
        rg_WE3 = 0; rg_A3 = 0; rg_WD3 = 0; rg_SB_SET = 0; rg_SB_A = 0; rg_A1 = 0; rg_A2 = 0;
        repeat (3) @(posedge clock);
        #1;
        if (rg_READY !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", rg_READY); end
        n_cmp++;
        if (rg_PEND1 !== 1'b0 || rg_PEND2 !== 1'b0) begin
            n_bad++; $display("FAIL reset_pend: got %b%b want 00", rg_PEND1, rg_PEND2);
        end
        n_cmp++;
        reset = 1'b1;
        wait_ready(cycles);
        if (cycles != NREG) begin n_bad++; $display("FAIL init_len: got %0d want %0d", cycles, NREG); end
        n_cmp++;
        drive(0, 0, 0, 0, 0, 5'd5, 5'd31);
        if (rg_RD1 !== 32'd5)  begin n_bad++; $display("FAIL init_rd1: got %h want 5", rg_RD1); end
        n_cmp++;
        if (rg_RD2 !== 32'd31) begin n_bad++; $display("FAIL init_rd2: got %h want 31", rg_RD2); end
        n_cmp++;
        drive(0, 0, 0, 0, 0, 5'd0, 5'd17);
        if (rg_RD1 !== 32'd0)  begin n_bad++; $display("FAIL init_rd0: got %h want 0", rg_RD1); end
        n_cmp++;
        if (rg_RD2 !== 32'd17) begin n_bad++; $display("FAIL init_rd17: got %h want 17", rg_RD2); end
        n_cmp++;
    endtask

    task automatic test_bypass();
        drive(1, 5'd7, 32'hDEAD_BEEF, 0, 0, 5'd7, 5'd7);
        if (rg_RD1 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL bypass_rd1: got %h want deadbeef", rg_RD1); end
        n_cmp++;
        if (rg_RD2 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL bypass_rd2: got %h want deadbeef", rg_RD2); end
        n_cmp++;
        step();
        drive(0, 5'd7, 32'h0, 0, 0, 5'd7, 5'd6);
        if (rg_RD1 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL written_rd1: got %h want deadbeef", rg_RD1); end
        n_cmp++;
        if (rg_RD2 !== 32'd6) begin n_bad++; $display("FAIL neighbour_rd2: got %h want 6", rg_RD2); end
        n_cmp++;
        step();
    endtask

    task automatic test_write_zero();
        drive(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 5'd0, 5'd0);
        if (rg_RD1 !== 32'd0) begin n_bad++; $display("FAIL zero_bypass: got %h want 0", rg_RD1); end
        n_cmp++;
        step();
        drive(0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        if (rg_RD1 !== 32'd0) begin n_bad++; $display("FAIL zero_read: got %h want 0", rg_RD1); end
        n_cmp++;
        step();
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0);
        if (rg_PEND1 !== 1'b0) begin n_bad++; $display("FAIL zero_pend: got %b want 0", rg_PEND1); end
        n_cmp++;
    endtask

    task automatic test_scoreboard();
        drive(0, 0, 0, 1, 5'd9, 5'd9, 5'd8);
        if (rg_PEND1 !== 1'b0) begin n_bad++; $display("FAIL sb_before: got %b want 0", rg_PEND1); end
        n_cmp++;
        step();
        drive(0, 0, 0, 0, 0, 5'd9, 5'd8);
        if (rg_PEND1 !== 1'b1) begin n_bad++; $display("FAIL sb_set: got %b want 1", rg_PEND1); end
        n_cmp++;
        if (rg_PEND2 !== 1'b0) begin n_bad++; $display("FAIL sb_other: got %b want 0", rg_PEND2); end
        n_cmp++;
        drive(1, 5'd9, 32'h0000_1234, 0, 0, 5'd9, 5'd9);
        if (rg_PEND1 !== 1'b0) begin n_bad++; $display("FAIL sb_clear_byp: got %b want 0", rg_PEND1); end
        n_cmp++;
        step();
        drive(0, 0, 0, 0, 0, 5'd9, 5'd9);
        if (rg_PEND2 !== 1'b0) begin n_bad++; $display("FAIL sb_cleared: got %b want 0", rg_PEND2); end
        n_cmp++;
    endtask

    task automatic test_set_write_same();
        drive(1, 5'd4, 32'h1234_5678, 1, 5'd4, 5'd4, 5'd4);
        if (rg_PEND1 !== 1'b0) begin n_bad++; $display("FAIL sw_same_cycle: got %b want 0", rg_PEND1); end
        n_cmp++;
        step();
        drive(0, 0, 0, 0, 0, 5'd4, 5'd4);
        if (rg_PEND1 !== 1'b1) begin n_bad++; $display("FAIL sw_pend: got %b want 1", rg_PEND1); end
        n_cmp++;
        if (rg_RD1 !== 32'h1234_5678) begin n_bad++; $display("FAIL sw_data: got %h want 12345678", rg_RD1); end
        n_cmp++;
        drive(1, 5'd4, 32'h0, 0, 0, 5'd4, 5'd4);
        step();
    endtask

    task automatic test_random();
        logic [AW-1:0] a1;
        for (int i = 0; i < 300; i++) begin
            a1 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            drive(($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom),
                  $urandom,
                  ($urandom_range(0, 9) < 3),
                  AW'($urandom_range(0, 7)),
                  a1,
                  ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom_range(0, 7)));
            if (rg_RD1 !== exp_rd(rg_A1)) begin n_bad++; $display("FAIL rand_rd1: got %h want %h", rg_RD1, exp_rd(rg_A1)); end
            n_cmp++;
            if (rg_RD2 !== exp_rd(rg_A2)) begin n_bad++; $display("FAIL rand_rd2: got %h want %h", rg_RD2, exp_rd(rg_A2)); end
            n_cmp++;
            if (rg_PEND1 !== exp_pend(rg_A1)) begin n_bad++; $display("FAIL rand_pend1: got %b want %b", rg_PEND1, exp_pend(rg_A1)); end
            n_cmp++;
            if (rg_PEND2 !== exp_pend(rg_A2)) begin n_bad++; $display("FAIL rand_pend2: got %b want %b", rg_PEND2, exp_pend(rg_A2)); end
            n_cmp++;
            if (rg_READY !== 1'b1) begin n_bad++; $display("FAIL rand_ready: got %b want 1", rg_READY); end
            n_cmp++;
            step();
        end
    endtask

    task automatic test_reset_mid_run();
        int cycles;
        drive(1, 5'd3, 32'h0000_0055, 1, 5'd3, 5'd3, 5'd3);
        step();
        drive(0, 0, 0, 0, 0, 5'd3, 5'd3);
        if (rg_RD1 !== 32'h55) begin n_bad++; $display("FAIL mid_pre_rd: got %h want 55", rg_RD1); end
        n_cmp++;
        if (rg_PEND1 !== 1'b1) begin n_bad++; $display("FAIL mid_pre_pend: got %b want 1", rg_PEND1); end
        n_cmp++;
        reset = 1'b0;
        m_run = 1'b0;
        #1;
        if (rg_READY !== 1'b0) begin n_bad++; $display("FAIL mid_ready: got %b want 0", rg_READY); end
        n_cmp++;
        if (rg_PEND1 !== 1'b0 || rg_PEND2 !== 1'b0) begin
            n_bad++; $display("FAIL mid_pend: got %b%b want 00", rg_PEND1, rg_PEND2);
        end
        n_cmp++;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        wait_ready(cycles);
        if (cycles != NREG) begin n_bad++; $display("FAIL reinit_len: got %0d want %0d", cycles, NREG); end
        n_cmp++;
        drive(0, 0, 0, 0, 0, 5'd3, 5'd31);
        if (rg_RD1 !== 32'd3) begin n_bad++; $display("FAIL reinit_rd3: got %h want 3", rg_RD1); end
        n_cmp++;
        if (rg_PEND1 !== 1'b0) begin n_bad++; $display("FAIL reinit_pend: got %b want 0", rg_PEND1); end
        n_cmp++;
        if (rg_RD2 !== 32'd31) begin n_bad++; $display("FAIL reinit_rd31: got %h want 31", rg_RD2); end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_write_zero();
        test_scoreboard();
        test_set_write_same();
        test_random();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
